// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU execute controller: sizes, opcodes, ALU codes, FSM states, field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int REG_AW  = 3;

  // Instruction opcodes (instr[15:12])
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;

  // Codes presented to the external ALU
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SHR = 3'd2;
  localparam logic [2:0] ALU_SHL = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOT = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  // Instruction field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Opcodes 0-7 go through the ALU
  function automatic logic op_is_alu(input logic [3:0] op);
    return !op[3];
  endfunction

  // Opcodes 0-8 write a register; anything above is illegal
  function automatic logic op_writes(input logic [3:0] op);
    return op <= OP_LDI;
  endfunction

  function automatic logic [2:0] op_to_alu_code(input logic [3:0] op);
    logic [2:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_SHR:  code = ALU_SHR;
      OP_SHL:  code = ALU_SHL;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_NOT:  code = ALU_NOT;
      OP_XOR:  code = ALU_XOR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 8x16 register file: two async operand reads, one async debug read, one synchronous write.
// Latency: reads combinational; a write is visible the cycle after its clock edge.
// Backpressure: none; a write is taken whenever we is high.
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

  // Next register contents: apply the single write port
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  // Register storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: IDLE->EXEC->WB sequencing, registered ALU drive, writeback and flags.
// Latency: accept at edge N, wb_valid during the cycle after edge N+1; register visible after edge N+2.
// Backpressure: instr_ready only in IDLE (also in WB when ALU_EXEC_CTRL_OVERLAP_EN is defined).
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_code,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_c,
  output logic              flag_z,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [2:0]        rd_q, rd_d;
  logic [7:0]        imm_q, imm_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_code_q, alu_code_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              carry_q, carry_d, zero_q, zero_d;
  logic              flag_c_q, flag_c_d, flag_z_q, flag_z_d;
  logic              illegal_q, illegal_d;

  logic              accept, wb_commit;
  logic [3:0]        in_op;
  logic [2:0]        in_rs, in_rt;
  logic [DATA_W-1:0] ra_data, rb_data, opa, opb;

  assign in_op = instr[OP_MSB:OP_LSB];
  assign in_rs = instr[RS_MSB:RS_LSB];
  assign in_rt = instr[RT_MSB:RT_LSB];

`ifdef ALU_EXEC_CTRL_OVERLAP_EN
  assign instr_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_WB));
`else
  assign instr_ready = rst_n && (state_q == ST_IDLE);
`endif

  assign accept    = instr_valid && instr_ready;
  assign wb_commit = (state_q == ST_WB) && op_writes(op_q);

  // An instruction accepted during WB must see the value being written this same edge
  assign opa = (wb_commit && (rd_q == in_rs)) ? res_q : ra_data;
  assign opb = (wb_commit && (rd_q == in_rt)) ? res_q : rb_data;

  alu_ctrl_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_commit),
    .wa       (rd_q),
    .wd       (res_q),
    .ra_addr  (in_rs),
    .ra_data  (ra_data),
    .rb_addr  (in_rt),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Next state, ALU drive (zero unless entering EXEC), result capture and flag update
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    res_d      = res_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    illegal_d  = illegal_q;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_code_d = '0;

    case (state_q)
      ST_EXEC: begin
        state_d = ST_WB;
        res_d   = (op_q == OP_LDI) ? {{(DATA_W-8){1'b0}}, imm_q} : alu_result;
        carry_d = alu_carry;
        zero_d  = alu_zero;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (op_is_alu(op_q)) begin
          flag_z_d = zero_q;
          if (op_q == OP_ADD) flag_c_d = carry_q;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = ST_EXEC;
      op_d    = in_op;
      rd_d    = instr[RD_MSB:RD_LSB];
      imm_d   = instr[IMM_MSB:IMM_LSB];
      if (op_is_alu(in_op)) begin
        alu_a_d    = opa;
        alu_b_d    = opb;
        alu_code_d = op_to_alu_code(in_op);
      end
      if (!op_writes(in_op)) illegal_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_code_q <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_code_q <= alu_code_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_code = alu_code_q;
  assign wb_valid = wb_commit;
  assign wb_addr  = wb_commit ? rd_q : '0;
  assign wb_data  = wb_commit ? res_q : '0;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: behavioural ALU, architectural reference model, randomized ops.
// Latency: n/a.
// Backpressure: instructions are held on instr until instr_ready is seen.
module tb_alu_exec_ctrl;

`ifdef ALU_EXEC_CTRL_OVERLAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_code;
  logic        alu_carry, alu_zero;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flag_c, flag_z, illegal;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;
  logic [16:0] alu_sum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ref_regs [8];
  logic        ref_c, ref_z, ref_ill;
  logic        last_seen;
  logic [15:0] last_d;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .flag_c(flag_c), .flag_z(flag_z), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural combinational ALU
  always_comb begin
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = 1'b0;
    case (alu_code)
      3'd0: begin alu_result = alu_sum[15:0]; alu_carry = alu_sum[16]; end
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a >> 1;
      3'd3: alu_result = alu_a << 1;
      3'd4: alu_result = alu_a & alu_b;
      3'd5: alu_result = alu_a | alu_b;
      3'd6: alu_result = ~alu_a;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_result == 16'h0);
  end

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int rt);
    logic [15:0] w;
    w = 16'((op << 12) | (rd << 9) | (rs << 6) | (rt << 3));
    return w;
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    logic [15:0] w;
    w = 16'((8 << 12) | (rd << 9) | (imm & 255));
    return w;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0;
    ref_c = 1'b0; ref_z = 1'b0; ref_ill = 1'b0;
  endtask

  // Architectural effect of one instruction, in plain integer arithmetic
  task automatic model(input logic [15:0] ins, output logic ewb, output logic [2:0] ea,
                       output logic [15:0] ed, output logic [15:0] eopa, output logic [15:0] eopb);
    int op, a, b, r;
    op   = int'(ins[15:12]);
    ea   = ins[11:9];
    eopa = ref_regs[ins[8:6]];
    eopb = ref_regs[ins[5:3]];
    a    = int'(eopa);
    b    = int'(eopb);
    ewb  = 1'b0;
    r    = 0;
    if (op == 8) begin
      r = int'(ins[7:0]); ewb = 1'b1;
    end else if (op < 8) begin
      ewb = 1'b1;
      case (op)
        0: begin r = a + b; ref_c = (r > 65535); end
        1: r = a - b + 65536;
        2: r = a / 2;
        3: r = a * 2;
        4: r = int'(eopa & eopb);
        5: r = int'(eopa | eopb);
        6: r = 65535 - a;
        default: r = int'(eopa ^ eopb);
      endcase
      r = r % 65536;
      ref_z = (r == 0);
    end else begin
      ref_ill = 1'b1;
    end
    ed = r[15:0];
    if (ewb) ref_regs[ea] = ed;
  endtask

  // Issue one instruction from a negedge, follow it to IDLE, compare against the model
  task automatic run_instr(input logic [15:0] ins);
    logic ewb, seen;
    logic [2:0] ea, ga;
    logic [15:0] ed, eopa, eopb, gd;
    int n, lat;
    model(ins, ewb, ea, ed, eopa, eopb);
    dbg_addr = ins[11:9];
    instr = ins; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    n_cmp++;
    if (!instr_ready) begin
      n_bad++; $display("FAIL ready_timeout: instr_ready stayed %b, want 1", instr_ready);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = 16'h0;
      n_cmp++;
      if (!ins[15]) begin
        if ({alu_a, alu_b, alu_code} !== {eopa, eopb, ins[14:12]}) begin
          n_bad++; $display("FAIL exec_drive %h: got a=%h b=%h c=%0d want a=%h b=%h c=%0d",
                            ins, alu_a, alu_b, alu_code, eopa, eopb, ins[14:12]);
        end
      end else if ({alu_a, alu_b, alu_code} !== 35'h0) begin
        n_bad++; $display("FAIL exec_idle_drive %h: got a=%h b=%h c=%0d want 0", ins, alu_a, alu_b, alu_code);
      end
      seen = 1'b0; lat = 0; ga = 3'd0; gd = 16'h0;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (wb_valid && !seen) begin seen = 1'b1; lat = k; ga = wb_addr; gd = wb_data; end
      end
      last_seen = seen; last_d = gd;
      n_cmp++;
      if (seen !== ewb) begin n_bad++; $display("FAIL wb_seen %h: got %b want %b", ins, seen, ewb); end
      if (ewb && seen) begin
        n_cmp++;
        if (lat != 2 || ga !== ea || gd !== ed) begin
          n_bad++; $display("FAIL wb %h: got lat=%0d addr=%0d data=%h want lat=2 addr=%0d data=%h",
                            ins, lat, ga, gd, ea, ed);
        end
      end
      n_cmp++;
      if ({flag_c, flag_z, illegal} !== {ref_c, ref_z, ref_ill}) begin
        n_bad++; $display("FAIL flags %h: got c=%b z=%b ill=%b want c=%b z=%b ill=%b",
                          ins, flag_c, flag_z, illegal, ref_c, ref_z, ref_ill);
      end
      n_cmp++;
      if (dbg_data !== ref_regs[ea]) begin
        n_bad++; $display("FAIL dbg r%0d: got %h want %h", ea, dbg_data, ref_regs[ea]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; instr_valid = 1'b1; instr = enc(0, 1, 2, 3);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
    n_cmp++;
    if ({alu_a, alu_b, alu_code, wb_valid, wb_addr, wb_data} !== 55'h0) begin
      n_bad++; $display("FAIL reset_outs: got a=%h b=%h c=%0d wbv=%b wba=%0d wbd=%h want 0",
                        alu_a, alu_b, alu_code, wb_valid, wb_addr, wb_data);
    end
    n_cmp++;
    if ({flag_c, flag_z, illegal} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b%b%b want 000", flag_c, flag_z, illegal);
    end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a); #1;
      n_cmp++;
      if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL reset_dbg r%0d: got %h want 0000", a, dbg_data); end
    end
    @(negedge clk);
    instr_valid = 1'b0; rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_instr(ldi(1, 8'hFF));
    run_instr(ldi(2, 8'h01));
    run_instr(enc(0, 3, 1, 2));
    n_cmp++;
    if ({last_d, flag_c, flag_z} !== {16'h0100, 2'b00}) begin
      n_bad++; $display("FAIL add_basic: got %h c=%b z=%b want 0100 c=0 z=0", last_d, flag_c, flag_z);
    end
    run_instr(ldi(4, 8'h00));
    run_instr(enc(1, 5, 4, 4));
    n_cmp++;
    if ({last_d, flag_z} !== {16'h0000, 1'b1}) begin
      n_bad++; $display("FAIL sub_zero: got %h z=%b want 0000 z=1", last_d, flag_z);
    end
  endtask

  task automatic test_carry;
    run_instr(ldi(1, 8'hFF));
    for (int i = 0; i < 8; i++) run_instr(enc(3, 1, 1, 0));
    run_instr(enc(0, 2, 1, 1));
    n_cmp++;
    if ({last_d, flag_c} !== {16'hFE00, 1'b1}) begin
      n_bad++; $display("FAIL add_carry: got %h c=%b want fe00 c=1", last_d, flag_c);
    end
    run_instr(enc(4, 3, 1, 2));
    n_cmp++;
    if (flag_c !== 1'b1) begin n_bad++; $display("FAIL carry_hold: got %b want 1", flag_c); end
  endtask

  task automatic test_illegal;
    run_instr(enc(4'hA, 3, 1, 2));
    n_cmp++;
    if ({last_seen, illegal} !== 2'b01) begin
      n_bad++; $display("FAIL illegal_op: got wb=%b ill=%b want wb=0 ill=1", last_seen, illegal);
    end
    run_instr(enc(5, 6, 1, 2));
    n_cmp++;
    if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_clear: got %b want 0", illegal); end
  endtask

  // instr_valid held high over a program; checks writeback spacing, chaining and ALU stability
  task automatic test_back_to_back;
    logic [15:0] prog[$];
    logic [15:0] exp_d[$], exp_a[$], exp_b[$];
    int wb_cyc[$];
    logic ewb;
    logic [2:0] ea;
    logic [15:0] ed, eopa, eopb, early_a, early_b, prev_a, prev_b;
    int idx, wb_cnt;
    logic acc;
    prog.push_back(ldi(1, 3));
    for (int i = 0; i < 4; i++) prog.push_back(enc(0, 1, 1, 1));
    for (int i = 0; i < 4; i++)
      prog.push_back(enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    foreach (prog[i]) begin
      model(prog[i], ewb, ea, ed, eopa, eopb);
      exp_d.push_back(ed);
      exp_a.push_back(prog[i][15] ? 16'h0 : eopa);
      exp_b.push_back(prog[i][15] ? 16'h0 : eopb);
    end
    idx = 0; wb_cnt = 0;
    instr = prog[0]; instr_valid = 1'b1;
    early_a = alu_a; early_b = alu_b;
    prev_a = 16'h0; prev_b = 16'h0;
    for (int cyc = 0; cyc < 60 && wb_cnt < prog.size(); cyc++) begin
      n_cmp++;
      if ({early_a, early_b} !== {alu_a, alu_b}) begin
        n_bad++; $display("FAIL alu_stable cyc%0d: got %h/%h late vs %h/%h early", cyc, alu_a, alu_b, early_a, early_b);
      end
      if (wb_valid) begin
        n_cmp++;
        if (wb_data !== exp_d[wb_cnt] || {prev_a, prev_b} !== {exp_a[wb_cnt], exp_b[wb_cnt]}) begin
          n_bad++; $display("FAIL b2b_wb %0d: got data=%h ops=%h/%h want data=%h ops=%h/%h",
                            wb_cnt, wb_data, prev_a, prev_b, exp_d[wb_cnt], exp_a[wb_cnt], exp_b[wb_cnt]);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_code} !== 35'h0) begin
          n_bad++; $display("FAIL wb_alu_zero: got a=%h b=%h c=%0d want 0", alu_a, alu_b, alu_code);
        end
        wb_cyc.push_back(cyc);
        wb_cnt++;
      end
      acc = instr_valid && instr_ready;
      prev_a = alu_a; prev_b = alu_b;
      @(posedge clk); #1;
      early_a = alu_a; early_b = alu_b;
      if (acc) begin
        idx++;
        if (idx < prog.size()) instr = prog[idx];
        else begin instr_valid = 1'b0; instr = 16'h0; end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (wb_cnt != prog.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", wb_cnt, prog.size()); end
    for (int i = 1; i < wb_cyc.size(); i++) begin
      n_cmp++;
      if (wb_cyc[i] - wb_cyc[i-1] != GAP) begin
        n_bad++; $display("FAIL b2b_gap %0d: got %0d want %0d", i, wb_cyc[i] - wb_cyc[i-1], GAP);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int op;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 9);
      if (op == 9) op = $urandom_range(9, 15);
      if (op == 8) run_instr(ldi($urandom_range(0, 7), $urandom_range(0, 255)));
      else run_instr(enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    end
  endtask

  task automatic test_reset_mid_exec;
    logic seen;
    int n;
    run_instr(ldi(7, 8'hC3));
    instr = ldi(6, 8'h5A); instr_valid = 1'b1; dbg_addr = 3'd6;
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    rst_n = 1'b0; instr_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (wb_valid) seen = 1'b1; end
    n_cmp++;
    if ({instr_ready, alu_a, alu_code} !== 20'h0) begin
      n_bad++; $display("FAIL midrst_outs: got rdy=%b a=%h c=%0d want 0", instr_ready, alu_a, alu_code);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    if (wb_valid) seen = 1'b1;
    n_cmp++;
    if ({seen, instr_ready} !== 2'b01) begin
      n_bad++; $display("FAIL midrst_abandon: got wb=%b rdy=%b want wb=0 rdy=1", seen, instr_ready);
    end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a); #1;
      n_cmp++;
      if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL midrst_dbg r%0d: got %h want 0000", a, dbg_data); end
    end
    @(negedge clk);
    run_instr(ldi(6, 8'h33));
  endtask

  initial begin
    model_reset();
    last_seen = 1'b0; last_d = 16'h0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
